// File: rtl/dense_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dense_pkg                                                     |
// | Purpose  : Shared types, default widths and the requantisation helper    |
// |            used by the time-multiplexed dense layer.                     |
// | Contents : dense_state_t  - FSM state encoding (IDLE/MAC/WB/DONE)        |
// |            c_* constants  - default layer geometry and word widths       |
// |            sat_trunc()    - shift right, saturate, optional ReLU         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package dense_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } dense_state_t;

    localparam int c_DATA_W = 16;
    localparam int c_FRAC_W = 8;
    localparam int c_N_IN   = 10;
    localparam int c_N_OUT  = 10;

    // Working width of sat_trunc; accumulators up to this width are supported.
    localparam int c_SAT_W  = 64;

    // Arithmetic shift (floor), clamp to a data_w-bit signed range, then ReLU.
    // The result is returned in c_SAT_W bits; callers keep the low data_w bits.
    function automatic logic signed [c_SAT_W-1:0] sat_trunc(
        input logic signed [c_SAT_W-1:0] acc,
        input int                        frac_w,
        input int                        data_w,
        input logic                      relu
    );
        logic signed [c_SAT_W-1:0] v;
        logic signed [c_SAT_W-1:0] hi;
        logic signed [c_SAT_W-1:0] lo;
        v  = acc >>> frac_w;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            v = hi;
        end else if (v < lo) begin
            v = lo;
        end
        if (relu && (v < 0)) begin
            v = '0;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fixp_requant.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fixp_requant                                                  |
// | Purpose  : Combinational requantiser: accumulator -> DATA_W output word. |
// |            Floor shift by FRAC_W, signed saturation, optional ReLU.      |
// | Ports    : i_acc  [ACC_W-1:0]  signed full-precision accumulator         |
// |            i_relu              clamp negative results to zero            |
// |            o_q    [DATA_W-1:0] signed requantised result                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fixp_requant
    import dense_pkg::*;
#(
    parameter int ACC_W  = 37,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    input  logic                     i_relu,
    output logic signed [DATA_W-1:0] o_q
);

    // Saturation guarantees the value fits DATA_W, so dropping upper bits is exact.
    assign o_q = DATA_W'(sat_trunc(c_SAT_W'(i_acc), FRAC_W, DATA_W, i_relu));

endmodule
`default_nettype wire

// File: rtl/dense_layer_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dense_layer_seq                                               |
// | Purpose  : Fully-connected layer on a single shared MAC engine. Walks    |
// |            neuron j = 0..N_OUT-1, accumulating bias + sum(in*w) over     |
// |            N_IN cycles, then requantises into out_vec[j] in one WB cycle.|
// | Ports    : clk, reset (sync, active-high)                                |
// |            start, relu_en, in_vec   - run request and captured operands  |
// |            weights, biases          - held stable by the host while busy |
// |            busy, done, out_valid    - run status / completion handshake  |
// |            out_vec                  - requantised neuron outputs         |
// |            argmax_idx               - only with DENSE_ARGMAX_EN defined  |
// | Options  : `define DENSE_ARGMAX_EN adds a running-max argmax output.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module dense_layer_seq
    import dense_pkg::*;
#(
    parameter int N_IN   = c_N_IN,
    parameter int N_OUT  = c_N_OUT,
    parameter int DATA_W = c_DATA_W,
    parameter int FRAC_W = c_FRAC_W,
    parameter int ACC_W  = 2*DATA_W + $clog2(N_IN) + 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic                                    relu_en,
    input  logic [N_IN-1:0][DATA_W-1:0]             in_vec,
    input  logic [N_OUT-1:0][N_IN-1:0][DATA_W-1:0]  weights,
    input  logic [N_OUT-1:0][DATA_W-1:0]            biases,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    out_valid,
    output logic [N_OUT-1:0][DATA_W-1:0]            out_vec
`ifdef DENSE_ARGMAX_EN
    ,
    output logic [$clog2(N_OUT)-1:0]                argmax_idx
`endif
);

    localparam int I_W = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int J_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    dense_state_t                    r_state;
    logic [I_W-1:0]                  r_i;
    logic [J_W-1:0]                  r_j;
    logic signed [ACC_W-1:0]         r_acc;
    logic [N_IN-1:0][DATA_W-1:0]     r_in;
    logic                            r_relu;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_out_valid;
    logic [N_OUT-1:0][DATA_W-1:0]    r_out_vec;

    logic signed [DATA_W-1:0]        w_in_sel;
    logic signed [DATA_W-1:0]        w_w_sel;
    logic signed [2*DATA_W-1:0]      w_prod;
    logic [J_W-1:0]                  w_jn;
    logic signed [ACC_W-1:0]         w_bias0;
    logic signed [ACC_W-1:0]         w_bias_nx;
    logic signed [DATA_W-1:0]        w_q;

    assign w_in_sel  = r_in[r_i];
    assign w_w_sel   = weights[r_j][r_i];
    assign w_prod    = w_in_sel * w_w_sel;
    assign w_jn      = r_j + J_W'(1);
    // Biases share the data Q-format, so they are aligned to the product
    // scale (2*FRAC_W fractional bits) before seeding the accumulator.
    assign w_bias0   = ACC_W'($signed(biases[0]))    <<< FRAC_W;
    assign w_bias_nx = ACC_W'($signed(biases[w_jn])) <<< FRAC_W;

    fixp_requant #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_requant (
        .i_acc  (r_acc),
        .i_relu (r_relu),
        .o_q    (w_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_acc       <= '0;
            r_in        <= '0;
            r_relu      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_vec   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_in        <= in_vec;
                        r_relu      <= relu_en;
                        r_i         <= '0;
                        r_j         <= '0;
                        r_acc       <= w_bias0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    if (r_i == I_W'(N_IN - 1)) begin
                        r_i     <= '0;
                        r_state <= ST_WB;
                    end else begin
                        r_i <= r_i + I_W'(1);
                    end
                end
                ST_WB: begin
                    r_out_vec[r_j] <= w_q;
                    if (r_j == J_W'(N_OUT - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_j     <= w_jn;
                        r_acc   <= w_bias_nx;
                        r_state <= ST_MAC;
                    end
                end
                ST_DONE: begin
                    r_done      <= 1'b1;
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_vec   = r_out_vec;

`ifdef DENSE_ARGMAX_EN
    logic signed [DATA_W-1:0] r_max;
    logic [J_W-1:0]           r_argmax;

    // Strict greater-than keeps the earliest index on ties; neuron 0 always
    // seeds the running max so stale values from a previous run never win.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_max    <= '0;
            r_argmax <= '0;
        end else if ((r_state == ST_WB) && ((r_j == '0) || (w_q > r_max))) begin
            r_max    <= w_q;
            r_argmax <= r_j;
        end
    end

    assign argmax_idx = r_argmax;
`endif

endmodule
`default_nettype wire
